// File: rtl/layer_trainer.sv
// Training sequencer driving a single-output learning layer from a stored sample table.
// Define LAYER_TRAINER_EARLY_STOP_EN to end a run at the first zero-miss epoch.
module layer_trainer #(
  parameter int N       = 16,
  parameter int SAMPLES = 8,
  parameter int EPOCHS  = 64,
  parameter int SETTLE  = 2,
  parameter int TOL     = 0,
  parameter int DATA_W  = 8,
  localparam int AW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1,
  localparam int EW = $clog2(EPOCHS + 1),
  localparam int MW = $clog2(SAMPLES + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load_en,
  input  logic [AW-1:0]              load_addr,
  input  logic [N-1:0][DATA_W-1:0]   load_in,
  input  logic [DATA_W-1:0]          load_target,
  input  logic                       start,
  input  logic                       abort,
  output logic [N-1:0][DATA_W-1:0]   in,
  output logic                       valid,
  output logic                       learn,
  output logic [DATA_W-1:0]          expected_out,
  input  logic [DATA_W-1:0]          out,
  output logic                       busy,
  output logic                       done,
  output logic                       converged,
  output logic [EW-1:0]              epoch_count,
  output logic [MW-1:0]              miss_count
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [AW-1:0]     LAST_IDX    = AW'(SAMPLES - 1);
  localparam logic [EW-1:0]     EPOCHS_C    = EW'(EPOCHS);
  localparam logic [MW-1:0]     MISS_MAX    = MW'(SAMPLES);
  localparam logic [DATA_W-1:0] TOL_C       = DATA_W'(TOL);
`ifdef LAYER_TRAINER_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_CHECK, S_LEARN, S_EVAL} state_t;

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] a);
    return (a >= MISS_MAX) ? MISS_MAX : (a + MW'(1));
  endfunction

  logic [N-1:0][DATA_W-1:0] tbl_in  [SAMPLES];
  logic [DATA_W-1:0]        tbl_tgt [SAMPLES];

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [MW-1:0]            acc_q, acc_d, miss_q, miss_d;
  logic [EW-1:0]            epoch_q, epoch_d;
  logic                     valid_q, valid_d, learn_q, learn_d, busy_q, busy_d;
  logic                     done_q, done_d, conv_q, conv_d;
  logic [N-1:0][DATA_W-1:0] in_q, in_d;
  logic [DATA_W-1:0]        exp_q, exp_d;
  logic                     addr_ok;

  assign addr_ok = ({{(32-AW){1'b0}}, load_addr} < SAMPLES);

  // Table holds no reset; it is only writable while idle.
  always_ff @(posedge clock) begin
    if (load_en && addr_ok && (state_q == S_IDLE)) begin
      tbl_in[load_addr]  <= load_in;
      tbl_tgt[load_addr] <= load_target;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    miss_d   = miss_q;
    epoch_d  = epoch_q;
    conv_d   = conv_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            epoch_d  = '0;
            idx_d    = '0;
            acc_d    = '0;
            settle_d = '0;
            state_d  = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (settle_q == SETTLE_LAST) state_d = S_CHECK;
          else settle_d = settle_q + SW'(1);
        end
        S_CHECK: begin
          if (abs_diff(out, exp_q) > TOL_C) acc_d = sat_inc(acc_q);
          state_d = S_LEARN;
        end
        S_LEARN: begin
          settle_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_EVAL;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_PRESENT;
          end
        end
        S_EVAL: begin
          miss_d  = acc_q;
          epoch_d = epoch_q + EW'(1);
          acc_d   = '0;
          idx_d   = '0;
          if ((epoch_d == EPOCHS_C) || (EARLY_STOP && (acc_q == '0))) begin
            done_d  = 1'b1;
            conv_d  = (acc_q == '0);
            state_d = S_IDLE;
          end else begin
            state_d = S_PRESENT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with it.
    valid_d = (state_d == S_PRESENT) || (state_d == S_CHECK) || (state_d == S_LEARN);
    learn_d = (state_d == S_LEARN);
    busy_d  = (state_d != S_IDLE);
    in_d    = in_q;
    exp_d   = exp_q;
    if (state_d == S_PRESENT) begin
      in_d  = tbl_in[idx_d];
      exp_d = tbl_tgt[idx_d];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      miss_q   <= '0;
      epoch_q  <= '0;
      valid_q  <= 1'b0;
      learn_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      conv_q   <= 1'b0;
      in_q     <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      miss_q   <= miss_d;
      epoch_q  <= epoch_d;
      valid_q  <= valid_d;
      learn_q  <= learn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      conv_q   <= conv_d;
      in_q     <= in_d;
      exp_q    <= exp_d;
    end
  end

  assign in           = in_q;
  assign expected_out = exp_q;
  assign valid        = valid_q;
  assign learn        = learn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign epoch_count  = epoch_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_layer_trainer.sv
// Directed bench for layer_trainer with a behavioural layer whose output error is selectable.
module tb_layer_trainer;

  localparam int N       = 4;
  localparam int SAMPLES = 8;
  localparam int EPOCHS  = 3;
  localparam int SETTLE  = 2;
  localparam int TOL     = 4;
  localparam int DATA_W  = 8;
  localparam int AW      = 3;
  localparam int EW      = 2;
  localparam int MW      = 4;
  localparam int EPOCH_CYC = SAMPLES * (SETTLE + 2) + 1;
`ifdef LAYER_TRAINER_EARLY_STOP_EN
  localparam int CONV_EPOCHS = 1;
`else
  localparam int CONV_EPOCHS = EPOCHS;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [N-1:0][DATA_W-1:0] load_in = '0;
  logic [DATA_W-1:0] load_target = '0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [N-1:0][DATA_W-1:0] in_w;
  logic valid, learn, busy, done, converged;
  logic [DATA_W-1:0] exp_w, lay_out;
  logic [EW-1:0] epoch_count;
  logic [MW-1:0] miss_count;

  int mode = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [N-1:0][DATA_W-1:0] ref_in [SAMPLES];
  logic [DATA_W-1:0]        ref_tgt [SAMPLES];

  layer_trainer #(.N(N), .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .SETTLE(SETTLE),
                  .TOL(TOL), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_in(load_in), .load_target(load_target), .start(start), .abort(abort),
    .in(in_w), .valid(valid), .learn(learn), .expected_out(exp_w), .out(lay_out),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
    .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // Layer model: exact, +5, +4, -5, or +5 only on odd targets.
  always_comb begin
    lay_out = exp_w;
    case (mode)
      1: lay_out = exp_w + 8'd5;
      2: lay_out = exp_w + 8'd4;
      3: lay_out = exp_w - 8'd5;
      4: lay_out = exp_w[0] ? (exp_w + 8'd5) : exp_w;
      default: lay_out = exp_w;
    endcase
  end

  // Protocol monitor: learn pulses, learn-within-valid, input stability, first-epoch capture.
  int learn_total = 0;
  int viol = 0;
  int pos = 0;
  logic busy_p = 1'b0, valid_p = 1'b0, learn_p = 1'b0;
  logic [N-1:0][DATA_W-1:0] in_p = '0;
  logic [DATA_W-1:0] exp_p = '0;
  logic [N-1:0][DATA_W-1:0] cap_in [SAMPLES];
  logic [DATA_W-1:0]        cap_tgt [SAMPLES];

  always @(negedge clock) begin
    busy_p  <= busy;
    valid_p <= valid;
    learn_p <= learn;
    in_p    <= in_w;
    exp_p   <= exp_w;
    if (learn) learn_total <= learn_total + 1;
    if ((learn && !valid) || (learn && learn_p) ||
        (valid && valid_p && !learn_p && ((in_w != in_p) || (exp_w != exp_p))))
      viol <= viol + 1;
    if (busy && !busy_p) begin
      pos <= 0;
    end else if (learn) begin
      if (pos < SAMPLES) begin
        cap_in[pos]  <= in_w;
        cap_tgt[pos] <= exp_w;
      end
      pos <= pos + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int m, input int exp_ep, input int exp_miss,
                     input bit exp_conv, input bit poke);
    int cyc;
    int l0;
    int v0;
    mode = m;
    l0 = learn_total;
    v0 = viol;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("busy_rise", 64'(busy), 64'd1);
    check_eq("valid_rise", 64'(valid), 64'd1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (poke && cyc == 5) begin
        start = 1'b1;
        load_en = 1'b1;
        load_addr = '0;
        load_in = {N{8'hEE}};
        load_target = 8'h77;
      end else begin
        start = 1'b0;
        load_en = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    load_en = 1'b0;
    check_eq("done_latency", 64'(cyc), 64'(exp_ep * EPOCH_CYC));
    check_eq("busy_at_done", 64'(busy), 64'd0);
    check_eq("epoch_count", 64'(epoch_count), 64'(exp_ep));
    check_eq("miss_count", 64'(miss_count), 64'(exp_miss));
    check_eq("converged", 64'(converged), 64'(exp_conv));
    @(negedge clock);
    check_eq("done_one_cycle", 64'(done), 64'd0);
    check_eq("learn_pulses", 64'(learn_total - l0), 64'(exp_ep * SAMPLES));
    check_eq("protocol_viol", 64'(viol - v0), 64'd0);
    for (int i = 0; i < SAMPLES; i++) begin
      check_eq($sformatf("in_order[%0d]", i), 64'(cap_in[i]), 64'(ref_in[i]));
      check_eq($sformatf("tgt_order[%0d]", i), 64'(cap_tgt[i]), 64'(ref_tgt[i]));
    end
  endtask

  initial begin
    int n;
    int dones;
    for (int i = 0; i < SAMPLES; i++) begin
      for (int j = 0; j < N; j++) ref_in[i][j] = 8'(16 * i + j + 1);
      ref_tgt[i] = 8'(10 + 3 * i);
    end

    repeat (2) @(negedge clock);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_learn", 64'(learn), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_conv", 64'(converged), 64'd0);
    check_eq("rst_epoch", 64'(epoch_count), 64'd0);
    check_eq("rst_miss", 64'(miss_count), 64'd0);
    check_eq("rst_in", 64'(in_w), 64'd0);
    check_eq("rst_exp", 64'(exp_w), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < SAMPLES; i++) begin
      load_en = 1'b1;
      load_addr = AW'(i);
      load_in = ref_in[i];
      load_target = ref_tgt[i];
      @(negedge clock);
    end
    load_en = 1'b0;
    @(negedge clock);

    run(0, CONV_EPOCHS, 0, 1'b1, 1'b0);
    run(1, EPOCHS, SAMPLES, 1'b0, 1'b0);
    run(2, CONV_EPOCHS, 0, 1'b1, 1'b0);
    run(3, EPOCHS, SAMPLES, 1'b0, 1'b0);
    run(4, EPOCHS, 4, 1'b0, 1'b0);

    // Abort during CHECK of sample index 3.
    mode = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(negedge clock);
      if (learn) n++;
    end
    check_eq("abort_reach", 64'(n), 64'd3);
    repeat (3) @(negedge clock);
    check_eq("pre_abort_check", 64'({valid, learn}), 64'b10);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_valid", 64'(valid), 64'd0);
    check_eq("abort_learn", 64'(learn), 64'd0);
    check_eq("abort_conv", 64'(converged), 64'd0);
    check_eq("abort_miss", 64'(miss_count), 64'd4);
    dones = (done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    check_eq("abort_no_done", 64'(dones), 64'd0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_idle", 64'(busy), 64'd0);

    run(0, CONV_EPOCHS, 0, 1'b1, 1'b1);
    run(0, CONV_EPOCHS, 0, 1'b1, 1'b0);

    // Asynchronous reset while learn is high.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && !learn; c++) begin
      @(negedge clock);
      n++;
    end
    check_eq("learn_seen", 64'(learn), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_learn", 64'(learn), 64'd0);
    check_eq("arst_valid", 64'(valid), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_epoch", 64'(epoch_count), 64'd0);
    check_eq("arst_miss", 64'(miss_count), 64'd0);
    check_eq("arst_conv", 64'(converged), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run(1, EPOCHS, SAMPLES, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_trainer.md
# layer_trainer

Training sequencer that drives a single-output learning layer from the opposite end of its interface. It stores a small table of input vectors and target outputs, presents them in order, and drives `valid`/`learn` and `expected_out`. It scores the layer's `out` against each target and repeats epochs until the layer converges or an epoch limit is reached. It sits between the host/test harness and the layer instance.

## Interface
- `N`, 16, input vector length; must match the layer's `N`
- `SAMPLES`, 8, number of training samples stored (≥1)
- `EPOCHS`, 64, maximum epochs per run (≥1)
- `SETTLE`, 2, cycles `in` is held with `valid=1, learn=0` before `out` is sampled (≥1)
- `TOL`, 0, max |out − target| (zero2one_t units) counted as a hit

- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `load_en`  in  1  write one sample-table entry this cycle
- `load_addr`  in  $clog2(SAMPLES) (min 1)  entry index
- `load_in`  in  zero2one_t × N  input vector for that entry
- `load_target`  in  zero2one_t  target output for that entry
- `start`  in  1  one-cycle pulse; begins a run
- `abort`  in  1  one-cycle pulse; ends a run without `done`
- `in`  out  zero2one_t × N  vector to the layer's `in`
- `valid`  out  1  to the layer's `valid`
- `learn`  out  1  to the layer's `learn`
- `expected_out`  out  zero2one_t × 1  target to the layer's `expected_out`
- `out`  in  zero2one_t × 1  from the layer's `out`
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of a run
- `converged`  out  1  last finished run ended with a zero-miss epoch
- `epoch_count`  out  $clog2(EPOCHS+1)  epochs completed in the current or last run
- `miss_count`  out  $clog2(SAMPLES+1)  misses in the most recently completed epoch

## Operation
- FSM states: IDLE, PRESENT, CHECK, LEARN, EVAL.
- IDLE: `valid=learn=0`, `busy=0`. `load_en` writes `load_in`/`load_target` to the table at `load_addr`; out-of-range addresses are ignored. On `start`, the block clears `epoch_count`, the sample index, and the miss accumulator, then goes to PRESENT.
- PRESENT: drives `in` and `expected_out` from the current table entry with `valid=1, learn=0` for exactly SETTLE cycles, then goes to CHECK.
- CHECK (1 cycle): `valid=1, learn=0`. Computes the unsigned |out − target|. If it exceeds TOL, the miss accumulator increments (saturating at SAMPLES). Goes to LEARN.
- LEARN (1 cycle): `valid=1, learn=1` with the same `in`/`expected_out`. A non-last sample increments the index and goes to PRESENT. The last sample goes to EVAL.
- EVAL (1 cycle): `valid=learn=0`. Copies the accumulator to `miss_count`, increments `epoch_count`, clears the accumulator, and resets the index to 0.
  - The run finishes when `epoch_count` reaches EPOCHS, or on an early stop (see Configuration).
  - On finish: pulse `done`, set `converged` = (epoch miss count == 0), go to IDLE.
  - Otherwise go to PRESENT.
- `start` and `load_en` are ignored while `busy=1`.
- `abort` in any non-IDLE state returns to IDLE next cycle. There is no `done` pulse; `converged` and `miss_count` are unchanged.
- `abort` takes priority over all other transitions.
- `in`/`expected_out` hold their last values in IDLE.

## Timing
- Reset values: FSM in IDLE; `in`, `expected_out`, `valid`, `learn`, `busy`, `done`, `converged`, `epoch_count`, `miss_count` all 0; index and accumulator 0. The table is not reset.
- `start` at cycle t: `busy=1` and `valid=1` from t+1.
- Each sample takes SETTLE+2 cycles. Each epoch takes SAMPLES·(SETTLE+2)+1 cycles.
- `done` is asserted for the single cycle after EVAL, coincident with `busy` falling. `epoch_count`, `miss_count` and `converged` are valid in that cycle.
- `learn` is never high unless `valid` is high. `learn` is high for exactly one cycle per sample.
- `start` and `abort` in the same IDLE cycle: `abort` wins and the block stays idle.
- Deasserting `reset_n` mid-run forces all outputs to reset values immediately (asynchronously).

## Configuration
- `LAYER_TRAINER_EARLY_STOP_EN` defined: the run finishes at the first EVAL with a zero miss count, even if `epoch_count` < EPOCHS.
- Undefined: every run lasts exactly EPOCHS epochs. `converged` reflects only the final epoch.

## Test plan
- Reset, load 2 samples, `start`, SETTLE=2, layer model with `out`=target -> early-stop build: `done` 9 cycles after `busy` rise, `epoch_count=1`, `miss_count=0`, `converged=1`. Non-early-stop build: runs EPOCHS epochs.
- Layer model always outputting target+5, TOL=4, SAMPLES=8, EPOCHS=3 -> `done` after 3 epochs, `miss_count=8`, `converged=0`, `epoch_count=3`.
- Monitor `valid`/`learn` over one epoch with SAMPLES=8 -> exactly 8 one-cycle `learn` pulses, each inside `valid`, and `in` stable from PRESENT through LEARN.
- `abort` in the CHECK state of sample 3 -> next cycle IDLE, `valid=learn=busy=0`, no `done`, prior `converged`/`miss_count` unchanged.
- `start` pulse while `busy=1`, and `load_en` while busy -> run unaffected, table unchanged (read back in the next run).
- Drop `reset_n` during LEARN -> `learn`/`valid` fall 0 without a clock edge, all counters 0; `start` after release begins a fresh run.
